// File: rtl/bp_be_fe_cmd_issuer.sv
// Back-end producer of the front-end command stream.
// Builds fe_cmd packets for boot state reset and attaboys, accepts preformed
// commands, and queues everything in order behind a valid/yumi interface.
//
// Packet layout, MSB first:
//   {opcode[2:0], npc[vaddr_width_p-1:0], operands[operands_width_lp-1:0]}
//   state reset operands: {0..., priv[1:0], translation_en}
//   attaboy operands:     {taken, branch_metadata_fwd}
// branch_metadata_fwd_width_p must be at least 2 so that the state reset
// operands fit.
module bp_be_fe_cmd_issuer #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36,
  parameter int els_p                       = 4,
  parameter int drop_ctr_width_p            = 16,
  localparam int opcode_width_lp            = 3,
  localparam int operands_width_lp          = branch_metadata_fwd_width_p + 1,
  localparam int fe_cmd_width_lp            = opcode_width_lp + vaddr_width_p + operands_width_lp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   init_done_i,
  input  logic [vaddr_width_p-1:0]               boot_pc_i,
  input  logic                                   cmd_v_i,
  input  logic [fe_cmd_width_lp-1:0]             cmd_i,
  output logic                                   cmd_ready_o,
  input  logic                                   attaboy_v_i,
  input  logic [vaddr_width_p-1:0]               attaboy_pc_i,
  input  logic                                   attaboy_taken_i,
  input  logic [branch_metadata_fwd_width_p-1:0] attaboy_metadata_i,
  input  logic                                   quiesce_i,
  output logic [fe_cmd_width_lp-1:0]             fe_cmd_o,
  output logic                                   fe_cmd_v_o,
  input  logic                                   fe_cmd_yumi_i,
  output logic                                   idle_o,
  output logic [drop_ctr_width_p-1:0]            attaboy_drop_count_o
);

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fill_response = 3'd2,
    e_op_branch_update        = 3'd3,
    e_op_attaboy              = 3'd4,
    e_op_icache_fence         = 3'd5,
    e_op_itlb_fill_response   = 3'd6,
    e_op_itlb_fence           = 3'd7
  } fe_cmd_opcode_e;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_boot  = 2'd1,
    e_run   = 2'd2,
    e_drain = 2'd3
  } state_e;

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  localparam logic [ptr_width_lp-1:0] ptr_last_lp   = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_lp        = cnt_width_lp'(els_p);
  // Attaboys may only fill up to els_p-1 entries, keeping one slot for a
  // mandatory command.
  localparam logic [cnt_width_lp-1:0] attaboy_max_lp = cnt_width_lp'(els_p - 2);

  state_e                       state_q, state_d;
  logic [ptr_width_lp-1:0]      wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]      rptr_q, rptr_d;
  logic [cnt_width_lp-1:0]      count_q, count_d;
  logic [drop_ctr_width_p-1:0]  drop_cnt_q, drop_cnt_d;
  logic                         cmd_ready_q, cmd_ready_d;
  logic                         fe_cmd_v_q, fe_cmd_v_d;
  logic                         idle_q, idle_d;

  logic [fe_cmd_width_lp-1:0]   mem [els_p];

  logic                         enq_v;
  logic [fe_cmd_width_lp-1:0]   enq_data;
  logic                         deq_v;
  logic                         attaboy_drop;
  logic [fe_cmd_width_lp-1:0]   reset_pkt;
  logic [fe_cmd_width_lp-1:0]   attaboy_pkt;

  // Fixed-format packets assembled from back-end inputs.
  always_comb begin
    reset_pkt   = {e_op_state_reset, boot_pc_i, operands_width_lp'(3'b110)};
    attaboy_pkt = {e_op_attaboy, attaboy_pc_i, attaboy_taken_i, attaboy_metadata_i};
  end

  // Enqueue arbitration and FSM next state; commands win over attaboys.
  always_comb begin
    state_d      = state_q;
    enq_v        = 1'b0;
    enq_data     = '0;
    attaboy_drop = 1'b0;
    case (state_q)
      e_reset: begin
        if (init_done_i) state_d = e_boot;
      end
      e_boot: begin
        // Queue is guaranteed empty here, so the boot packet always fits.
        enq_v    = 1'b1;
        enq_data = reset_pkt;
        state_d  = e_run;
      end
      e_run: begin
        if (cmd_v_i && cmd_ready_q) begin
          enq_v    = 1'b1;
          enq_data = cmd_i;
        end else if (attaboy_v_i && (count_q <= attaboy_max_lp)) begin
          enq_v    = 1'b1;
          enq_data = attaboy_pkt;
        end
        attaboy_drop = attaboy_v_i & ~(enq_v & ~cmd_v_i) & ~(enq_v & ~cmd_ready_q);
        if (quiesce_i) state_d = e_drain;
      end
      e_drain: begin
        // Attaboys offered while draining are discarded silently.
        if (!quiesce_i) state_d = e_run;
      end
      default: state_d = e_reset;
    endcase
  end

  // Pointer, occupancy and drop-counter updates, plus registered outputs
  // derived from the next state so they carry no input-to-output path.
  always_comb begin
    deq_v  = fe_cmd_yumi_i & fe_cmd_v_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq_v) wptr_d = (wptr_q == ptr_last_lp) ? '0 : wptr_q + 1'b1;
    if (deq_v) rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + 1'b1;

    count_d = count_q;
    if (enq_v && !deq_v)      count_d = count_q + 1'b1;
    else if (!enq_v && deq_v) count_d = count_q - 1'b1;

    drop_cnt_d = drop_cnt_q;
    if (attaboy_drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;

    cmd_ready_d = (state_d == e_run) && (count_d < els_lp);
    fe_cmd_v_d  = (count_d != '0);
    idle_d      = (state_d == e_drain) && (count_d == '0);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_reset;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      fe_cmd_v_q  <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      fe_cmd_v_q  <= fe_cmd_v_d;
      idle_q      <= idle_d;
    end
  end

  // Queue storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq_v) mem[wptr_q] <= enq_data;
  end

  assign fe_cmd_o             = mem[rptr_q];
  assign fe_cmd_v_o           = fe_cmd_v_q;
  assign cmd_ready_o          = cmd_ready_q;
  assign idle_o               = idle_q;
  assign attaboy_drop_count_o = drop_cnt_q;

endmodule

// File: doc/bp_be_fe_cmd_issuer.md
# bp_be_fe_cmd_issuer

Back-end producer of the front-end command stream. Assembles `bp_fe_cmd_s` packets from back-end events: boot state reset, redirects, fill responses, fences, and attaboys. Buffers them in a small in-order queue and presents them on the `fe_cmd` valid/yumi interface consumed by the front-end controller. It reserves queue space so that redirects and other mandatory commands are never lost, while attaboys are dropped under pressure.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: supplies `vaddr_width_p`, `branch_metadata_fwd_width_p`, and through `declare_bp_core_if_widths` the `fe_cmd_width_lp`.
- `els_p`, 4: queue depth. Must be at least 2.
- `drop_ctr_width_p`, 16: width of the attaboy-drop counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `init_done_i` in 1: back end is ready to boot the front end.
- `boot_pc_i` in `vaddr_width_p`: npc of the state-reset command.
- `cmd_v_i` in 1: preformed non-attaboy command is valid.
- `cmd_i` in `fe_cmd_width_lp`: the preformed command. Its opcode must not be `e_op_attaboy` or `e_op_state_reset`.
- `cmd_ready_o` out 1: `cmd_i` is accepted when `cmd_v_i & cmd_ready_o`.
- `attaboy_v_i` in 1: attaboy request. Best effort, no handshake.
- `attaboy_pc_i` in `vaddr_width_p`: attaboy npc.
- `attaboy_taken_i` in 1: attaboy taken bit.
- `attaboy_metadata_i` in `branch_metadata_fwd_width_p`: attaboy branch metadata.
- `quiesce_i` in 1: stop accepting new commands and drain the queue.
- `fe_cmd_o` out `fe_cmd_width_lp`: head packet.
- `fe_cmd_v_o` out 1: head packet is valid.
- `fe_cmd_yumi_i` in 1: front end consumed the head packet. Legal only while `fe_cmd_v_o` is high.
- `idle_o` out 1: in `e_drain` and the queue is empty.
- `attaboy_drop_count_o` out `drop_ctr_width_p`: saturating count of dropped attaboys.

## Operation
FSM states are `e_reset`, `e_boot`, `e_run`, `e_drain`.
- **`e_reset`**
  - Entered on reset.
  - Leaves to `e_boot` when `init_done_i` is high.
- **`e_boot`**
  - Enqueues one packet with `opcode=e_op_state_reset`, `npc=boot_pc_i`, `priv=3` (M), `translation_en=0`, all other fields 0.
  - Moves to `e_run` in the same cycle.
  - The queue is always empty here, so the enqueue never fails.
- **`e_run`**
  - `cmd_ready_o = (count_r < els_p)`.
  - Attaboys build packets with `opcode=e_op_attaboy`, `npc=attaboy_pc_i`, and `operands.attaboy.{taken, branch_metadata_fwd}` from the inputs.
  - Attaboy enqueue condition: `attaboy_v_i & ~(cmd_v_i & cmd_ready_o) & (count_r <= els_p-2)`.
  - Otherwise the attaboy is dropped and `attaboy_drop_count_o` increments, saturating at all-ones.
  - At most one enqueue per cycle. A preformed command has priority over an attaboy.
  - `quiesce_i` moves the FSM to `e_drain`. Commands accepted in that same cycle are still enqueued.
- **`e_drain`**
  - `cmd_ready_o=0`. Attaboys are dropped, but not counted.
  - `idle_o = (count_r==0)`.
  - Returns to `e_run` when `quiesce_i` deasserts.

Queue behaviour:
- Circular buffer with `$clog2(els_p)`-bit read and write pointers and a `count_r` of width `$clog2(els_p+1)`.
- Pointers wrap from `els_p-1` to 0.
- `fe_cmd_v_o = (count_r != 0)`. `fe_cmd_o` is the entry at the read pointer.
- Dequeue happens on `fe_cmd_yumi_i`.
- Strictly in order, with no reordering or squash of queued entries.
- A simultaneous enqueue and dequeue leaves `count_r` unchanged.

## Timing
- Reset values: state `e_reset`, pointers and `count_r` 0, `fe_cmd_v_o=0`, `cmd_ready_o=0`, `idle_o=0`, `attaboy_drop_count_o=0`. `fe_cmd_o` is don't-care while `fe_cmd_v_o=0`.
- Reset is asynchronous on assertion, and deassertion is synchronized externally. Reset mid-operation discards all queued entries and the next boot reissues the state reset.
- Enqueue latency: a packet accepted at edge t appears on `fe_cmd_o` with `fe_cmd_v_o=1` in cycle t+1 at the earliest. There is no bypass.
- `cmd_ready_o` and `fe_cmd_v_o` depend only on registered state. There is no combinational path from `fe_cmd_yumi_i` or `cmd_v_i`.
- Full queue: `cmd_ready_o=0` even if `fe_cmd_yumi_i` is asserted in the same cycle. Space frees on the next cycle.
- The attaboy reservation guarantees at least one free slot for a mandatory command whenever attaboys are the only pending traffic.

## Test plan
- **Boot:** release reset, hold `init_done_i=0` for 5 cycles, then raise it with `boot_pc_i=0x8000_0000`.
  - Required: one cycle in `e_boot`, then `fe_cmd_v_o=1` with `opcode=e_op_state_reset`, `npc=0x80000000`, `priv=3`.
  - Yumi it: `fe_cmd_v_o` drops.
- **Ordering:** with yumi held low, enqueue redirect A, attaboy B, then fence C.
  - Required: `count_r=3`, then yumi every cycle gives output order A, B, C.
- **Full and backpressure** (`els_p=4`): with yumi held low, issue 5 back-to-back `cmd_v_i`.
  - Required: the first 4 are accepted and `cmd_ready_o=0` on the 5th.
  - One yumi gives `cmd_ready_o=1` on the following cycle.
- **Attaboy reservation:** queue holds 3 entries and `attaboy_v_i=1`.
  - Required: the attaboy is dropped and `attaboy_drop_count_o` goes 0 to 1.
  - A `cmd_v_i` in the next cycle is still accepted.
- **Priority collision:** `cmd_v_i` and `attaboy_v_i` in the same cycle with the queue empty.
  - Required: only the command is enqueued, and the drop count increments.
- **Quiesce, then reset:**
  - Assert `quiesce_i` with 2 entries queued. Required: `cmd_ready_o=0`, and `idle_o` rises the cycle after the second yumi.
  - Assert `reset_n_i=0` with the queue non-empty. Required: `fe_cmd_v_o=0` immediately, without waiting for a clock edge.
